ackfifo_ctrl: RTL

- Synchronous FIFO controller that drives the ACKFIFO USRAM wrapper from the write/read-control side.
- Generates RAM write/read addresses and enables, tracks occupancy, and prefetches RAM read data into an output skid buffer so the user read port is first-word-fall-through (FWFT).
- Sits between the ACK producer logic and the ACK consumer; the RAM is instantiated beside it and wired through the RAM_* ports.

---
 rtl/ackfifo_pkg.sv | 20 ++
 rtl/ackfifo_skid.sv | 54 +++++
 rtl/ackfifo_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/ackfifo_pkg.sv
// Shared defaults, sizing helper and count type for the ACKFIFO controller.
package ackfifo_pkg;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 128;
  localparam int DEF_AW       = clog2_f(DEF_DEPTH);
  localparam int DEF_RD_LAT   = 2;
  localparam int DEF_SKID     = DEF_RD_LAT + 1;
  localparam int DEF_AFULL_TH = 124;

  typedef logic [DEF_AW:0] count_t;

endpackage

// File: rtl/ackfifo_skid.sv
// Small circular output buffer that holds prefetched RAM words; the head
// word comes straight from registered storage so Q never sees RAM timing.
module ackfifo_skid
  import ackfifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SKID  = DEF_SKID,
  parameter int CW    = clog2_f(SKID + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  localparam int IW = (SKID > 1) ? clog2_f(SKID) : 1;

  logic [WIDTH-1:0] mem_q [SKID];
  logic [IW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    return (idx == IW'(SKID - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    wr_d  = push_i ? wrap_inc(wr_q) : wr_q;
    rd_d  = pop_i ? wrap_inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SKID; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= push_data_i;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ackfifo_ctrl.sv
// FWFT FIFO controller for the ACKFIFO USRAM: pointers, occupancy, read
// prefetch with credit control into a skid buffer, and status flags.
module ackfifo_ctrl
  import ackfifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int AFULL_TH = DEF_AFULL_TH
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             WE,
  input  logic [WIDTH-1:0] DATA,
  output logic             FULL,
  output logic             AFULL,
  input  logic             RE,
  output logic [WIDTH-1:0] Q,
  output logic             EMPTY,
  output logic [AW:0]      COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic [AW-1:0]    RAM_WADDR,
  output logic [WIDTH-1:0] RAM_WDATA,
  output logic             RAM_WEN,
  output logic [AW-1:0]    RAM_RADDR,
  output logic             RAM_REN,
  input  logic [WIDTH-1:0] RAM_RDATA
);

  localparam int SKID = RD_LAT + 1;
  localparam int SW   = clog2_f(SKID + 1);

  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d, ram_cnt_q, ram_cnt_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [SW-1:0]     skid_cnt, inflight, occ;
  logic              skid_empty, push, pop, fetch, capture;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + SW'(pipe_q[i]);
  end

  assign occ     = inflight + skid_cnt;
  assign push    = WE & ~FULL;
  assign pop     = RE & ~skid_empty;
  // A same-cycle pop frees its slot before any new fetch can land, so it
  // counts as credit; this is what lets a full pipeline stream at 1/cycle.
  assign fetch   = (ram_cnt_q != '0) & ((occ < SW'(SKID)) | pop);
  assign capture = pipe_q[RD_LAT-1];

  always_comb begin
    wptr_d    = wptr_q + AW'(push);
    rptr_d    = rptr_q + AW'(fetch);
    count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    ram_cnt_d = ram_cnt_q + (AW+1)'(push) - (AW+1)'(fetch);
    pipe_d    = (pipe_q << 1) | RD_LAT'(fetch);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ram_cnt_q <= '0;
      pipe_q    <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ram_cnt_q <= ram_cnt_d;
      pipe_q    <= pipe_d;
    end
  end

  ackfifo_skid #(
    .WIDTH(WIDTH),
    .SKID (SKID),
    .CW   (SW)
  ) u_skid (
    .clk_i      (CLOCK),
    .rst_i      (RESET),
    .push_i     (capture),
    .push_data_i(RAM_RDATA),
    .pop_i      (pop),
    .head_o     (Q),
    .count_o    (skid_cnt),
    .empty_o    (skid_empty)
  );

  assign EMPTY     = skid_empty;
  assign FULL      = (count_q == (AW+1)'(DEPTH));
  assign AFULL     = (count_q >= (AW+1)'(AFULL_TH));
  assign COUNT     = count_q;
  assign OVERFLOW  = WE & FULL;
  assign UNDERFLOW = RE & skid_empty;
  assign RAM_WADDR = wptr_q;
  assign RAM_WDATA = DATA;
  assign RAM_WEN   = push;
  assign RAM_RADDR = rptr_q;
  assign RAM_REN   = fetch;

endmodule
